rx_perf_meas_multi: RTL and testbench
=====================================

Name: rx_perf_meas_multi

Overview:
- Parametrised successor to the single-rail receive performance block.
- Measures NCH independent 4-ASK rails per window of 2^LOG2_N symbols: rail I and Q for 16-QAM, default NCH=2.
- Per rail, per window: estimates the slicer reference level, slices, and produces decisions, average power, mean squared error and DC error.
- Sits after the sync stage on the decimated symbol stream. Adds a start/continuous control FSM and a result-valid handshake.

Parameters:
- DATA_W, 18, sample width, signed 1s17.
- NCH, 2, number of rails.
- LOG2_N, 8, log2 of symbols per measurement window.

Ports:
- sys_clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- sym_clk_en  in  1  symbol strobe. Minimum spacing 4 sys_clk cycles.
- start  in  1  one-cycle pulse; begins acquisition from IDLE.
- cont  in  1  1 = run windows back-to-back; 0 = single measurement.
- rx_in  in  NCH*DATA_W  packed synced symbols; rail k is bits [k*DATA_W +: DATA_W].
- rx_data  out  2*NCH  per-rail decision, 2 bits per rail: 00=-3, 01=-1, 10=+1, 11=+3.
- ref_level  out  NCH*DATA_W  per-rail mean |x|, used as the slicer threshold.
- avg_power  out  NCH*DATA_W  per-rail mean x^2.
- mse  out  NCH*DATA_W  per-rail mean err^2.
- dc_err  out  NCH*DATA_W  per-rail mean err, signed.
- meas_valid  out  1  one-cycle pulse when the outputs above are updated.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: all outputs and accumulators 0; state IDLE; symbol counter 0.
- FSM states: IDLE, ACQ, MEAS.
  - IDLE -> ACQ on start.
  - ACQ -> MEAS after 2^LOG2_N strobes.
  - MEAS -> MEAS at window end if cont=1; MEAS -> IDLE if cont=0.
  - start is ignored when not in IDLE.
- ACQ:
  - Accumulate |x| only. At window end, ref_level = sum>>LOG2_N.
  - No meas_valid pulse for the ACQ window.
- MEAS slicer, per rail, with T = ref_level:
  - x >= T -> +3, level 3T/2.
  - 0 <= x < T -> +1, level T/2.
  - -T <= x < 0 -> -1, level -T/2.
  - x < -T -> -3, level -3T/2.
- Decision output: rx_data is registered and updates on every strobe while in MEAS. It holds its value otherwise.
- Error and squares:
  - err = x - level, in DATA_W+1 bits.
  - Squares keep product bits [2*DATA_W-2 -: DATA_W]. Saturate to 2^(DATA_W-1)-1 on overflow (e.g. x = -1.0).
- Accumulators:
  - Width DATA_W+LOG2_N+1, signed; no wrap possible.
  - Sums |x|, x^2, err^2 and err.
- Window end in MEAS, per rail:
  - avg_power, mse and dc_err = sum>>>LOG2_N (arithmetic shift; dc_err truncates toward -inf).
  - ref_level refreshes from this window's mean |x|. It is used from the next window onward.
  - Accumulators clear. The first symbol of the next window is accumulated into the cleared accumulators, with no symbol lost.
- Pipeline and latency:
  - 3 stages: input register, slice/error, square/accumulate.
  - meas_valid pulses exactly 3 sys_clk cycles after the strobe cycle that samples the window's last symbol.
  - Result outputs change in that same cycle and are stable until the next pulse.
- Symbol counter: LOG2_N bits, wraps 2^LOG2_N-1 -> 0, advances only on sym_clk_en.
- cont is sampled at the window-end strobe.
- Asynchronous reset mid-window: state returns to IDLE, partial sums are discarded, and no meas_valid is issued.
- ref_level = 0, e.g. with an all-zero input: all x >= 0 map to +3 and negatives to -3. No special casing.

Optional Feature:
- Macro: RX_PERF_PEAK_ERR_EN.
- When defined: adds output peak_err (NCH*DATA_W), the per-rail max |err| over the MEAS window.
  - Updates with meas_valid; reset value 0.
  - Per-window tracker clears at window start.
  - |err| saturates at 2^(DATA_W-1)-1.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Ideal signal: both rails drive random levels from {±16384, ±49152}, start pulse, cont=0.
  - ACQ gives ref_level=32768.
  - MEAS gives avg_power=10240, mse=0, dc_err=0.
  - rx_data matches the transmitted symbols; exactly one meas_valid, then busy falls.
- Constant offset of +1024 on rail 0 only:
  - rail 0: dc_err=1024, mse=8.
  - rail 1: dc_err=0, mse=0.
  - Rails stay independent.
- Continuous run, cont=1, for 3 windows:
  - meas_valid pulses spaced exactly 2^LOG2_N strobes apart.
  - No symbol is dropped at window boundaries; checked with a counting pattern.
  - Dropping cont mid-window stops after that window.
- Saturation: input held at -131072 (-1.0) → avg_power=131071 (saturated); no wrap in accumulators.
- Reset and start handling:
  - reset_n low for 1 cycle at symbol 100 of MEAS → outputs 0, IDLE, no meas_valid.
  - A start during busy is ignored, checked by unchanged window timing.
- With RX_PERF_PEAK_ERR_EN defined: one symbol with err=+5000 injected in the window → peak_err=5000 on that rail, 0 on the other.

Source files
------------

// File: rtl/rx_perf_meas_multi.sv
// Per-rail 4-ASK measurement over 2^LOG2_N-symbol windows: slicer reference, decisions, power, MSE, DC error.
// Define RX_PERF_PEAK_ERR_EN to add the per-rail peak |err| output peak_err.
module rx_perf_meas_multi #(
    parameter int DATA_W = 18,
    parameter int NCH    = 2,
    parameter int LOG2_N = 8
) (
    input  logic                  sys_clk,
    input  logic                  reset_n,
    input  logic                  sym_clk_en,
    input  logic                  start,
    input  logic                  cont,
    input  logic [NCH*DATA_W-1:0] rx_in,
    output logic [2*NCH-1:0]      rx_data,
    output logic [NCH*DATA_W-1:0] ref_level,
    output logic [NCH*DATA_W-1:0] avg_power,
    output logic [NCH*DATA_W-1:0] mse,
    output logic [NCH*DATA_W-1:0] dc_err,
`ifdef RX_PERF_PEAK_ERR_EN
    output logic [NCH*DATA_W-1:0] peak_err,
`endif
    output logic                  meas_valid,
    output logic                  busy
);
    localparam int EW    = DATA_W + 1;
    localparam int SW    = DATA_W + 2;
    localparam int ACC_W = DATA_W + LOG2_N + 1;
    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, ACQ, MEAS} state_t;
    state_t state, state_nxt;
    logic [LOG2_N-1:0] sym_cnt;
    logic win_end;

    assign win_end = sym_clk_en && (sym_cnt == '1);
    assign busy    = (state != IDLE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = ACQ;
            ACQ:     if (win_end) state_nxt = MEAS;
            MEAS:    if (win_end && !cont) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            sym_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE)   sym_cnt <= '0;
            else if (sym_clk_en) sym_cnt <= sym_cnt + 1'b1;
        end
    end

    // Square keeping product bits [2*DATA_W-2 -: DATA_W], saturated to the positive maximum
    function automatic logic [DATA_W-1:0] sq_sat(input logic signed [EW-1:0] v);
        logic signed [2*EW-1:0] ve, p;
        ve = {{EW{v[EW-1]}}, v};
        p  = ve * ve;
        if (p[2*EW-1:2*DATA_W-2] != '0) return MAX_POS;
        return p[2*DATA_W-2 -: DATA_W];
    endfunction

    // Stage 1: input register
    logic s1_vld, s1_meas, s1_last;
    logic signed [DATA_W-1:0] s1_x [NCH];

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld  <= 1'b0;
            s1_meas <= 1'b0;
            s1_last <= 1'b0;
            for (int unsigned k = 0; k < NCH; k++) s1_x[k] <= '0;
        end else begin
            s1_vld <= sym_clk_en && busy;
            if (sym_clk_en && busy) begin
                s1_meas <= (state == MEAS);
                s1_last <= (sym_cnt == '1);
                for (int unsigned k = 0; k < NCH; k++) s1_x[k] <= rx_in[k*DATA_W +: DATA_W];
            end
        end
    end

    // Stage 2: slice against the current reference and form the error
    logic [1:0]               dec_c [NCH];
    logic signed [EW-1:0]     err_c [NCH];
    logic [DATA_W-1:0]        mag_c [NCH];

    always_comb begin
        logic signed [SW-1:0] xe, te, half, lvl3, lvl, diff, negx;
        xe = '0; te = '0; half = '0; lvl3 = '0; lvl = '0; diff = '0; negx = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            xe   = {{2{s1_x[k][DATA_W-1]}}, s1_x[k]};
            te   = {2'b00, ref_level[k*DATA_W +: DATA_W]};
            half = te >>> 1;
            lvl3 = te + half;
            if (xe >= te) begin
                dec_c[k] = 2'b11;
                lvl      = lvl3;
            end else if (!xe[SW-1]) begin
                dec_c[k] = 2'b10;
                lvl      = half;
            end else if (xe >= -te) begin
                dec_c[k] = 2'b01;
                lvl      = -half;
            end else begin
                dec_c[k] = 2'b00;
                lvl      = -lvl3;
            end
            diff     = xe - lvl;
            err_c[k] = diff[EW-1:0];
            negx     = -xe;
            mag_c[k] = xe[SW-1] ? negx[DATA_W-1:0] : xe[DATA_W-1:0];
        end
    end

    logic s2_vld, s2_meas, s2_last;
    logic signed [DATA_W-1:0] s2_x   [NCH];
    logic signed [EW-1:0]     s2_err [NCH];
    logic [DATA_W-1:0]        s2_mag [NCH];

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_vld  <= 1'b0;
            s2_meas <= 1'b0;
            s2_last <= 1'b0;
            rx_data <= '0;
            for (int unsigned k = 0; k < NCH; k++) begin
                s2_x[k]   <= '0;
                s2_err[k] <= '0;
                s2_mag[k] <= '0;
            end
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_meas <= s1_meas;
                s2_last <= s1_last;
                for (int unsigned k = 0; k < NCH; k++) begin
                    s2_x[k]   <= s1_x[k];
                    s2_err[k] <= err_c[k];
                    s2_mag[k] <= mag_c[k];
                    if (s1_meas) rx_data[2*k +: 2] <= dec_c[k];
                end
            end
        end
    end

    // Stage 3: square, accumulate, and at window end publish the means
    logic signed [ACC_W-1:0] acc_abs [NCH], acc_pow [NCH], acc_mse [NCH], acc_err [NCH];
    logic signed [ACC_W-1:0] nxt_abs [NCH], nxt_pow [NCH], nxt_mse [NCH], nxt_err [NCH];
    logic [DATA_W-1:0]       mean_abs [NCH], mean_pow [NCH], mean_mse [NCH], mean_err [NCH];
`ifdef RX_PERF_PEAK_ERR_EN
    logic [DATA_W-1:0]       aerr_c [NCH], acc_peak [NCH], nxt_peak [NCH];
`endif

    always_comb begin
        logic signed [ACC_W-1:0] sh_abs, sh_pow, sh_mse, sh_err;
        sh_abs = '0; sh_pow = '0; sh_mse = '0; sh_err = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            nxt_abs[k] = acc_abs[k] + $signed({{(ACC_W-DATA_W){1'b0}}, s2_mag[k]});
            nxt_pow[k] = acc_pow[k] + $signed({{(ACC_W-DATA_W){1'b0}}, sq_sat({s2_x[k][DATA_W-1], s2_x[k]})});
            nxt_mse[k] = acc_mse[k] + $signed({{(ACC_W-DATA_W){1'b0}}, sq_sat(s2_err[k])});
            nxt_err[k] = acc_err[k] + $signed({{(ACC_W-EW){s2_err[k][EW-1]}}, s2_err[k]});
            sh_abs = nxt_abs[k] >>> LOG2_N;
            sh_pow = nxt_pow[k] >>> LOG2_N;
            sh_mse = nxt_mse[k] >>> LOG2_N;
            sh_err = nxt_err[k] >>> LOG2_N;
            // mean |x| of a full-scale negative rail is 2^(DATA_W-1); clamp so T stays positive
            mean_abs[k] = (sh_abs[ACC_W-1:DATA_W-1] != '0) ? MAX_POS : sh_abs[DATA_W-1:0];
            mean_pow[k] = sh_pow[DATA_W-1:0];
            mean_mse[k] = sh_mse[DATA_W-1:0];
            mean_err[k] = sh_err[DATA_W-1:0];
        end
    end

`ifdef RX_PERF_PEAK_ERR_EN
    always_comb begin
        logic signed [EW-1:0] nege, ae;
        nege = '0; ae = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            nege      = -s2_err[k];
            ae        = s2_err[k][EW-1] ? nege : s2_err[k];
            aerr_c[k] = (ae[EW-1:DATA_W-1] != '0) ? MAX_POS : ae[DATA_W-1:0];
            nxt_peak[k] = (aerr_c[k] > acc_peak[k]) ? aerr_c[k] : acc_peak[k];
        end
    end
`endif

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            meas_valid <= 1'b0;
            ref_level  <= '0;
            avg_power  <= '0;
            mse        <= '0;
            dc_err     <= '0;
`ifdef RX_PERF_PEAK_ERR_EN
            peak_err   <= '0;
            for (int unsigned k = 0; k < NCH; k++) acc_peak[k] <= '0;
`endif
            for (int unsigned k = 0; k < NCH; k++) begin
                acc_abs[k] <= '0;
                acc_pow[k] <= '0;
                acc_mse[k] <= '0;
                acc_err[k] <= '0;
            end
        end else begin
            meas_valid <= 1'b0;
            if (s2_vld) begin
                if (s2_last && s2_meas) meas_valid <= 1'b1;
                for (int unsigned k = 0; k < NCH; k++) begin
                    if (s2_last) begin
                        acc_abs[k] <= '0;
                        acc_pow[k] <= '0;
                        acc_mse[k] <= '0;
                        acc_err[k] <= '0;
                        ref_level[k*DATA_W +: DATA_W] <= mean_abs[k];
`ifdef RX_PERF_PEAK_ERR_EN
                        acc_peak[k] <= '0;
`endif
                        if (s2_meas) begin
                            avg_power[k*DATA_W +: DATA_W] <= mean_pow[k];
                            mse[k*DATA_W +: DATA_W]       <= mean_mse[k];
                            dc_err[k*DATA_W +: DATA_W]    <= mean_err[k];
`ifdef RX_PERF_PEAK_ERR_EN
                            peak_err[k*DATA_W +: DATA_W]  <= nxt_peak[k];
`endif
                        end
                    end else begin
                        acc_abs[k] <= nxt_abs[k];
                        if (s2_meas) begin
                            acc_pow[k] <= nxt_pow[k];
                            acc_mse[k] <= nxt_mse[k];
                            acc_err[k] <= nxt_err[k];
`ifdef RX_PERF_PEAK_ERR_EN
                            acc_peak[k] <= nxt_peak[k];
`endif
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_rx_perf_meas_multi.sv
// Randomised directed bench for rx_perf_meas_multi against a window-level arithmetic reference model.
`timescale 1ns/1ps
module tb_rx_perf_meas_multi;
    localparam int DW = 18, NCH = 2, LN = 8, N = 256;
    localparam longint MAXV = 131071;

    logic sys_clk = 1'b0;
    logic reset_n, sym_clk_en, start, cont;
    logic [NCH*DW-1:0] rx_in;
    logic [2*NCH-1:0]  rx_data;
    logic [NCH*DW-1:0] ref_level, avg_power, mse, dc_err;
`ifdef RX_PERF_PEAK_ERR_EN
    logic [NCH*DW-1:0] peak_err;
`endif
    logic meas_valid, busy;

    int n_assert = 0, n_fail = 0;
    longint wx [NCH][N];
    int     m_dec [NCH][N];
    longint m_ref [NCH], m_pow [NCH], m_mse [NCH], m_dc [NCH], m_peak [NCH];

    always #5 sys_clk = ~sys_clk;

    rx_perf_meas_multi #(.DATA_W(DW), .NCH(NCH), .LOG2_N(LN)) dut (
        .sys_clk(sys_clk), .reset_n(reset_n), .sym_clk_en(sym_clk_en), .start(start), .cont(cont),
        .rx_in(rx_in), .rx_data(rx_data), .ref_level(ref_level), .avg_power(avg_power), .mse(mse),
        .dc_err(dc_err),
`ifdef RX_PERF_PEAK_ERR_EN
        .peak_err(peak_err),
`endif
        .meas_valid(meas_valid), .busy(busy)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no end of test, expected end within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [63:0] fld(input logic [NCH*DW-1:0] v, input int k);
        logic signed [DW-1:0] f;
        f = v[k*DW +: DW];
        return f;
    endfunction

    function automatic longint sq_sat(input longint v);
        longint p;
        p = (v * v) / 131072;
        return (p > MAXV) ? MAXV : p;
    endfunction

    function automatic longint floor_mean(input longint s);
        longint q;
        q = s / N;
        if (s < 0 && q * N != s) q = q - 1;
        return q;
    endfunction

    // Reference: decisions for the window under the current reference, then window means
    task automatic model_window(input bit is_meas, input bit commit);
        for (int k = 0; k < NCH; k++) begin
            longint t, x, lvl, e, ae, s_abs, s_pow, s_mse, s_err, pk;
            int d;
            t = m_ref[k]; s_abs = 0; s_pow = 0; s_mse = 0; s_err = 0; pk = 0;
            for (int i = 0; i < N; i++) begin
                x = wx[k][i];
                s_abs += (x < 0) ? -x : x;
                if (x >= t)       begin d = 3; lvl = (3 * t) / 2;    end
                else if (x >= 0)  begin d = 2; lvl = t / 2;          end
                else if (x >= -t) begin d = 1; lvl = -(t / 2);       end
                else              begin d = 0; lvl = -((3 * t) / 2); end
                e = x - lvl;
                m_dec[k][i] = d;
                s_pow += sq_sat(x);
                s_mse += sq_sat(e);
                s_err += e;
                ae = (e < 0) ? -e : e;
                if (ae > MAXV) ae = MAXV;
                if (ae > pk) pk = ae;
            end
            if (commit) begin
                m_ref[k] = floor_mean(s_abs);
                if (m_ref[k] > MAXV) m_ref[k] = MAXV;
                if (is_meas) begin
                    m_pow[k] = floor_mean(s_pow);
                    m_mse[k] = floor_mean(s_mse);
                    m_dc[k]  = floor_mean(s_err);
                    m_peak[k] = pk;
                end
            end
        end
    endtask

    task automatic gen_ideal(input longint off0);
        longint lv [4] = '{-49152, -16384, 16384, 49152};
        for (int k = 0; k < NCH; k++) begin
            for (int i = 0; i < N; i++) wx[k][i] = lv[i % 4];
            for (int i = N - 1; i > 0; i--) begin
                int j;
                longint t;
                j = int'($urandom_range(i, 0));
                t = wx[k][i]; wx[k][i] = wx[k][j]; wx[k][j] = t;
            end
        end
        for (int i = 0; i < N; i++) wx[0][i] += off0;
    endtask

    task automatic gen_ramp(input int w);
        for (int k = 0; k < NCH; k++)
            for (int i = 0; i < N; i++)
                wx[k][i] = longint'(i - 128) * 1000 + k * 333 + w * 7 + longint'($urandom_range(15, 0));
    endtask

    task automatic gen_const(input longint v);
        for (int k = 0; k < NCH; k++)
            for (int i = 0; i < N; i++) wx[k][i] = v;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
        check("busy after start", busy, 1);
    endtask

    // One strobe every 4 cycles; meas_valid must appear only 3 cycles after the last MEAS strobe
    task automatic play_window(input bit is_meas, input int n_sym, input int start_at, input int drop_at,
                               input bit chk_all);
        model_window(is_meas, n_sym == N);
        for (int i = 0; i < n_sym; i++) begin
            for (int k = 0; k < NCH; k++) begin
                longint tmp;
                tmp = wx[k][i];
                rx_in[k*DW +: DW] = tmp[DW-1:0];
            end
            sym_clk_en = 1'b1;
            if (i == start_at) start = 1'b1;
            if (i == drop_at) cont = 1'b0;
            @(posedge sys_clk); #1;
            sym_clk_en = 1'b0;
            start = 1'b0;
            for (int j = 1; j <= 3; j++) begin
                @(posedge sys_clk); #1;
                check("meas_valid timing", meas_valid, (is_meas && i == N - 1 && j == 2));
                if (is_meas && i == N - 1 && j == 2) begin
                    for (int k = 0; k < NCH; k++) begin
                        check($sformatf("avg_power r%0d", k), fld(avg_power, k), m_pow[k]);
                        if (chk_all) begin
                            check($sformatf("mse r%0d", k), fld(mse, k), m_mse[k]);
                            check($sformatf("dc_err r%0d", k), fld(dc_err, k), m_dc[k]);
                            check($sformatf("ref_level r%0d", k), fld(ref_level, k), m_ref[k]);
`ifdef RX_PERF_PEAK_ERR_EN
                            check($sformatf("peak_err r%0d", k), fld(peak_err, k), m_peak[k]);
`endif
                        end
                    end
                end
            end
            if (is_meas && chk_all)
                for (int k = 0; k < NCH; k++)
                    check($sformatf("rx_data r%0d sym%0d", k, i), rx_data[2*k +: 2], m_dec[k][i]);
        end
        if (n_sym == N) begin
            if (!is_meas && chk_all)
                for (int k = 0; k < NCH; k++)
                    check($sformatf("acq ref_level r%0d", k), fld(ref_level, k), m_ref[k]);
            check("busy at window end", busy, (!is_meas || cont));
        end
    endtask

    initial begin
        reset_n = 1'b0; sym_clk_en = 1'b0; start = 1'b0; cont = 1'b0; rx_in = '0;
        for (int k = 0; k < NCH; k++) m_ref[k] = 0;
        repeat (3) @(posedge sys_clk);
        #1 reset_n = 1'b1;
        @(posedge sys_clk); #1;
        check("reset rx_data", rx_data, 0);
        check("reset ref_level", ref_level, 0);
        check("reset avg_power", avg_power, 0);
        check("reset mse", mse, 0);
        check("reset dc_err", dc_err, 0);
        check("reset meas_valid", meas_valid, 0);
        check("reset busy", busy, 0);

        // Ideal constellation, single shot, with start pokes while busy
        pulse_start();
        gen_ideal(0);
        play_window(0, N, 50, -1, 1);
        check("ideal acq ref r0", fld(ref_level, 0), 32768);
        check("ideal acq ref r1", fld(ref_level, 1), 32768);
        gen_ideal(0);
        play_window(1, N, 200, -1, 1);
        for (int k = 0; k < NCH; k++) begin
            check("ideal avg_power", fld(avg_power, k), 10240);
            check("ideal mse", fld(mse, k), 0);
            check("ideal dc_err", fld(dc_err, k), 0);
        end
        repeat (8) @(posedge sys_clk);
        #1 check("idle after single", busy, 0);

        // DC offset on rail 0 only
        pulse_start();
        gen_ideal(1024);
        play_window(0, N, -1, -1, 1);
        gen_ideal(1024);
        play_window(1, N, -1, -1, 1);
        check("offset dc_err r0", fld(dc_err, 0), 1024);
        check("offset mse r0", fld(mse, 0), 8);
        check("offset dc_err r1", fld(dc_err, 1), 0);
        check("offset mse r1", fld(mse, 1), 0);

        // Continuous: three back-to-back windows of counting ramps, cont dropped mid third window
        cont = 1'b1;
        pulse_start();
        gen_ramp(0);
        play_window(0, N, -1, -1, 1);
        for (int w = 1; w <= 3; w++) begin
            gen_ramp(w);
            play_window(1, N, -1, (w == 3) ? 100 : -1, 1);
        end
        check("cont stopped", busy, 0);

        // Full-scale negative input: power saturates
        cont = 1'b0;
        pulse_start();
        gen_const(-131072);
        play_window(0, N, -1, -1, 0);
        gen_const(-131072);
        play_window(1, N, -1, -1, 0);
        check("sat avg_power r0", fld(avg_power, 0), 131071);
        check("sat avg_power r1", fld(avg_power, 1), 131071);

        // Single large error on rail 0
        pulse_start();
        gen_ideal(0);
        play_window(0, N, -1, -1, 1);
        gen_ideal(0);
        wx[0][77] += 5000;
        play_window(1, N, -1, -1, 1);
`ifdef RX_PERF_PEAK_ERR_EN
        check("peak_err r0", fld(peak_err, 0), 5000);
        check("peak_err r1", fld(peak_err, 1), 0);
`endif

        // Asynchronous reset at symbol 100 of MEAS
        pulse_start();
        gen_ideal(0);
        play_window(0, N, -1, -1, 1);
        gen_ideal(0);
        play_window(1, 100, -1, -1, 1);
        reset_n = 1'b0;
        @(posedge sys_clk); #1;
        reset_n = 1'b1;
        for (int k = 0; k < NCH; k++) m_ref[k] = 0;
        check("mid reset rx_data", rx_data, 0);
        check("mid reset ref_level", ref_level, 0);
        check("mid reset avg_power", avg_power, 0);
        check("mid reset mse", mse, 0);
        check("mid reset dc_err", dc_err, 0);
        check("mid reset busy", busy, 0);
        play_window(0, 160, -1, -1, 1);
        check("post reset busy", busy, 0);
        check("post reset rx_data", rx_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
